// File: rtl/ram_multiport.sv
// Word memory with one byte-enabled write port, NUM_RD registered read ports
// (stall/flush per port, write-first forwarding) and a sequential clear engine.
module ram_multiport #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD-1:0]        rd_flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [WIDTH/8-1:0]       wr_be,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NBYTES = WIDTH / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic                    clr_busy_q, clr_busy_d;
    logic                    clr_done_q, clr_done_d;
    logic [NUM_RD*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]       rd_valid_q, rd_valid_d;

    logic [IDX_W-1:0] wr_idx;
    logic             ext_wr;
    logic [WIDTH-1:0] wr_merged;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [WIDTH-1:0] mem_wdata;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_word;

    // Only the word-index bits of each address are meaningful; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr, wr_addr};

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_busy_d = clr_busy_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    clr_cnt_d  = '0;
                    clr_busy_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                // Busy drops as the last word is zeroed so it spans exactly DEPTH cycles.
                if (clr_cnt_q == LAST_IDX) begin
                    state_d    = ST_DONE;
                    clr_cnt_d  = '0;
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                clr_busy_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_idx    = wr_addr[IDX_W+1:2];
        ext_wr    = wr_en && !clr_busy_q;
        wr_merged = mem[wr_idx];
        for (int k = 0; k < NBYTES; k++) begin
            if (wr_be[k]) begin
                wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
        mem_we    = 1'b0;
        mem_idx   = wr_idx;
        mem_wdata = wr_merged;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_wdata = '0;
        end else if (ext_wr && (|wr_be)) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_idx     = '0;
        rd_word    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_idx  = rd_addr[i*ADDR_W+2 +: IDX_W];
            // Write-first: a same-cycle write to this index is seen by the read.
            rd_word = (ext_wr && (rd_idx == wr_idx)) ? wr_merged : mem[rd_idx];
            if (rd_flush[i]) begin
                rd_data_d[i*WIDTH +: WIDTH] = '0;
                rd_valid_d[i]               = 1'b0;
            end else if (clr_busy_q) begin
                rd_valid_d[i] = 1'b0;
            end else if (rd_en[i]) begin
                rd_data_d[i*WIDTH +: WIDTH] = rd_word;
                rd_valid_d[i]               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_ram_multiport.sv
// Bench for ram_multiport: a word-array reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_ram_multiport;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int NUM_RD = 2;
    localparam int ADDR_W = 32;

    logic                     clk;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD-1:0]        rd_flush;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]  rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [WIDTH-1:0]         wr_data;
    logic [WIDTH/8-1:0]       wr_be;
    logic                     clr_start;
    logic                     clr_busy;
    logic                     clr_done;

    int vector_count = 0;
    int fail_count   = 0;

    // Reference state: the array, per-port expected outputs, clear progress.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_data [NUM_RD];
    logic        exp_valid [NUM_RD];
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    int          clr_left = 0;
    bit          cooldown = 0;

    ram_multiport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_flush(rd_flush), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vector_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [1:0] fl,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic we, input logic [31:0] wa,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic cs);
        @(negedge clk);
        rd_en     = en;
        rd_flush  = fl;
        rd_addr   = {a1, a0};
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_be     = be;
        clr_start = cs;
    endtask

    task automatic idleCycle();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic sampleAfterEdge();
        @(posedge clk);
        #2;
    endtask

    // Reference model: word index is addr/4 mod DEPTH; clearing takes DEPTH
    // cycles, then one cycle in which a new clear request is ignored.
    initial begin
        int w_idx;
        int r_idx;
        bit busy_now;
        logic [31:0] w_merged;
        logic [31:0] word;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        for (int p = 0; p < NUM_RD; p++) begin
            exp_data[p]  = 32'h0;
            exp_valid[p] = 1'b0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    exp_data[p]  = 32'h0;
                    exp_valid[p] = 1'b0;
                end
                clr_left = 0;
                cooldown = 0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end else begin
                busy_now = (clr_left > 0);
                w_idx    = (wr_addr / 4) % DEPTH;
                w_merged = mergeBytes(ref_mem[w_idx], wr_data, wr_be);
                for (int p = 0; p < NUM_RD; p++) begin
                    r_idx = (rd_addr[p*32 +: 32] / 4) % DEPTH;
                    word  = ref_mem[r_idx];
                    if (wr_en && !busy_now && r_idx == w_idx) word = w_merged;
                    if (rd_flush[p]) begin
                        exp_data[p]  = 32'h0;
                        exp_valid[p] = 1'b0;
                    end else if (busy_now) begin
                        exp_valid[p] = 1'b0;
                    end else if (rd_en[p]) begin
                        exp_data[p]  = word;
                        exp_valid[p] = 1'b1;
                    end
                end
                exp_done = 1'b0;
                if (busy_now) begin
                    ref_mem[DEPTH - clr_left] = 32'h0;
                    clr_left = clr_left - 1;
                    if (clr_left == 0) begin
                        exp_done = 1'b1;
                        cooldown = 1;
                    end
                end else begin
                    if (wr_en) ref_mem[w_idx] = w_merged;
                    if (cooldown) cooldown = 0;
                    else if (clr_start) clr_left = DEPTH;
                end
                exp_busy = (clr_left > 0);
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    checkOutput($sformatf("model_port%0d_data", p),
                                64'(rd_data[p*32 +: 32]), 64'(exp_data[p]));
                    checkOutput($sformatf("model_port%0d_valid", p),
                                64'(rd_valid[p]), 64'(exp_valid[p]));
                end
                checkOutput("model_clr_busy", 64'(clr_busy), 64'(exp_busy));
                checkOutput("model_clr_done", 64'(clr_done), 64'(exp_done));
            end
        end
    end

    initial begin
        int busy_cycles;
        int done_pulses;
        rst       = 1'b1;
        rd_en     = '0;
        rd_flush  = '0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        clr_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_rd_data", 64'(rd_data), 64'h0);
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'h0);
        checkOutput("reset_clr_busy", 64'(clr_busy), 64'h0);
        checkOutput("reset_clr_done", 64'(clr_done), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full clear; a second request, a write and reads land mid-clear.
        busy_cycles = 0;
        done_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 0)
                applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            else if (i == 50)
                applyStimulus(2'b11, 2'b00, 32'h20, 32'h10, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1);
            else
                idleCycle();
            sampleAfterEdge();
            if (clr_busy) busy_cycles++;
            if (clr_done) done_pulses++;
        end
        checkOutput("clear_busy_cycles", 64'(busy_cycles), 64'd256);
        checkOutput("clear_done_pulses", 64'(done_pulses), 64'd1);
        applyStimulus(2'b11, 2'b00, 32'h20, 32'h3FC, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("clear_ignored_write", 64'(rd_data[31:0]), 64'h0);
        checkOutput("clear_last_word", 64'(rd_data[63:32]), 64'h0);

        // Basic write then read; port1 uses a low-bit-offset alias.
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        applyStimulus(2'b11, 2'b00, 32'h10, 32'h13, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("basic_port0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        checkOutput("basic_port1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        checkOutput("basic_valid", 64'(rd_valid), 64'h3);

        // Partial byte write forwarded to a same-cycle read.
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 1'b0);
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h10, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0);
        sampleAfterEdge();
        checkOutput("forward_port1", 64'(rd_data[63:32]), 64'h11BB_33DD);
        applyStimulus(2'b01, 2'b00, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("forward_later_read", 64'(rd_data[31:0]), 64'h11BB_33DD);

        // Stall holds the output while the word changes; flush beats enable.
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h20, 32'h5, 4'hF, 1'b0);
        applyStimulus(2'b01, 2'b00, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("stall_initial", 64'(rd_data[31:0]), 64'h5);
        for (int i = 0; i < 3; i++)
            applyStimulus(2'b00, 2'b00, 32'h20, 32'h0, 1'b1, 32'h20, 32'h99 + 32'(i), 4'hF, 1'b0);
        sampleAfterEdge();
        checkOutput("stall_hold_data", 64'(rd_data[31:0]), 64'h5);
        checkOutput("stall_hold_valid", 64'(rd_valid[0]), 64'h1);
        applyStimulus(2'b01, 2'b01, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("flush_data", 64'(rd_data[31:0]), 64'h0);
        checkOutput("flush_valid", 64'(rd_valid[0]), 64'h0);

        // Address aliasing modulo DEPTH words; zero byte enables write nothing.
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h400, 32'h1, 4'hF, 1'b0);
        applyStimulus(2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("alias_read", 64'(rd_data[31:0]), 64'h1);
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 1'b0);
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h800, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("zero_be_noop", 64'(rd_data[63:32]), 64'h1);

        // Reset during clear cycle 100: indices below 100 zeroed, the rest kept.
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h18C, 32'hA5A5_A5A5, 4'hF, 1'b0);
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h190, 32'h1234, 4'hF, 1'b0);
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h320, 32'h5678, 4'hF, 1'b0);
        applyStimulus(2'b11, 2'b00, 32'h320, 32'h190, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i <= 100; i++) begin
            if (i == 0)
                applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            else
                idleCycle();
            sampleAfterEdge();
        end
        rst = 1'b1;
        #1;
        checkOutput("midclear_busy", 64'(clr_busy), 64'h0);
        checkOutput("midclear_data", 64'(rd_data), 64'h0);
        checkOutput("midclear_done", 64'(clr_done), 64'h0);
        idleCycle();
        idleCycle();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 32'h18C, 32'h190, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("midclear_idx99", 64'(rd_data[31:0]), 64'h0);
        checkOutput("midclear_idx100", 64'(rd_data[63:32]), 64'h1234);
        applyStimulus(2'b11, 2'b00, 32'h320, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        sampleAfterEdge();
        checkOutput("midclear_idx200", 64'(rd_data[31:0]), 64'h5678);
        checkOutput("midclear_idx0", 64'(rd_data[63:32]), 64'h0);
        checkOutput("midclear_no_done", 64'(clr_done), 64'h0);

        idleCycle();
        idleCycle();
        sampleAfterEdge();
        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule

// File: doc/ram_multiport.md
Name: ram_multiport

Overview:
Parametrised synchronous word memory for the pipelined core: one byte-enabled write port, NUM_RD independent registered read ports with per-port stall/flush, and a sequential clear engine.
- Replaces fixed two-port instruction storage.
- Serves instruction fetch and data access from one array.
- Write-first forwarding keeps same-cycle write/read coherent without pipeline hazards.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 256, number of words; must be a power of two, at least 2
NUM_RD, 2, number of read ports, 1..8
ADDR_W, 32, byte-address width of every address port

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd_en  in  NUM_RD  per-port read enable; 0 means stall (hold output)
rd_flush  in  NUM_RD  per-port flush; zeroes that port's output register
rd_addr  in  NUM_RD*ADDR_W  per-port byte address; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*WIDTH  per-port registered read data; port i uses [i*WIDTH +: WIDTH]
rd_valid  out  NUM_RD  per-port flag: rd_data holds a word fetched by an accepted read
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write byte address
wr_data  in  WIDTH  write data
wr_be  in  WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k]
clr_start  in  1  request to zero the whole array
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Addressing: word index = addr[$clog2(DEPTH)+1:2]; bits [1:0] and bits above the index are ignored, so addresses alias modulo DEPTH words.
- Reset (asynchronous): rd_data = 0, rd_valid = 0, clr_busy = 0, clr_done = 0, FSM = IDLE, clear counter = 0. Array contents are not reset.
- Read priority per port, evaluated at posedge:
  - rd_flush: rd_data <= 0, rd_valid <= 0.
  - else clr_busy: hold rd_data, rd_valid <= 0.
  - else rd_en: rd_data <= word, rd_valid <= 1.
  - else: hold rd_data and rd_valid.
- Read latency is 1 cycle. Ports are fully independent; any number of ports may read the same index in the same cycle.
- Write, when wr_en=1 and clr_busy=0: byte lanes with wr_be[k]=1 are updated at posedge. wr_be=0 with wr_en=1 is a no-op.
- Forwarding: if a read is accepted in the same cycle as a write to the same index, rd_data receives the merged word. Enabled lanes come from wr_data; other lanes come from the old array contents (write-first).
- Clear FSM:
  - IDLE: clr_start=1 -> CLEAR, counter <= 0, clr_busy <= 1.
  - CLEAR: writes 0 to array[counter] each cycle and increments counter. External writes are ignored. After writing index DEPTH-1 -> DONE.
  - DONE: clr_busy <= 0, clr_done <= 1 for exactly one cycle -> IDLE.
  - Total clr_busy high time is DEPTH cycles.
- clr_start while in CLEAR or DONE is ignored (no restart, no queuing).
- Reset mid-clear: FSM returns to IDLE immediately and no clr_done pulse is produced. Partially cleared words stay zero; the rest are unchanged.
- Counter width is $clog2(DEPTH); terminal detection uses counter == DEPTH-1 and must not rely on overflow.

Test Plan:
- Basic R/W, WIDTH=32: write 0xDEADBEEF to addr 0x10 (wr_be=4'hF), then port0 reads 0x10 -> next cycle rd_data[0]=0xDEADBEEF, rd_valid[0]=1; port1 reads 0x13 in the same cycle -> same value (low bits ignored).
- Byte enables + forwarding: array[4]=0x11223344; in one cycle write 0xAABBCCDD with wr_be=4'b0101 to addr 0x10 and read 0x10 on port1 -> rd_data[1]=0x11BB33DD; a later read returns 0x11BB33DD.
- Stall/flush: port0 holds 0x5; hold rd_en=0 for 3 cycles while writing new data -> rd_data unchanged. Assert rd_flush together with rd_en -> rd_data=0, rd_valid=0.
- Aliasing with DEPTH=256: write 0x1 to addr 0x400, then read addr 0x0 -> 0x1.
- Clear: pulse clr_start -> clr_busy high exactly 256 cycles, writes ignored and rd_valid=0 throughout, then a single clr_done pulse; any read afterwards returns 0. A second clr_start mid-clear does not extend busy.
- Reset mid-clear: assert rst at clear cycle 100 -> clr_busy=0 and rd_data=0 within the same cycle, no clr_done. Words at indices <100 read 0; words at indices ≥100 keep their prior values.
